tt_coin_input_conditioner: RTL and testbench
============================================

Name: tt_coin_input_conditioner

Overview:
- Upstream front-end of the vending machine core (tt_Maquina_Top).
- Takes the four raw, asynchronous coin/command switches, ordered {P,R,N,D} on bits 3..0.
- Synchronises and debounces each switch, then converts each press into a single-cycle event.
- Issues at most one event per clock, so the machine FSM never sees two inputs in the same cycle.

Parameters:
- N_CH, 4, number of input channels.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its stable value before the stable value changes; must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable (Tiny Tapeout ena).
- sw_raw  input  N_CH  raw switches, bit3=P, bit2=R, bit1=N, bit0=D.
- sw_level  output  N_CH  debounced stable level per channel.
- sw_pulse  output  N_CH  one-hot or zero; one-cycle press event for the machine core.
- pend  output  N_CH  presses debounced but not yet issued (debug/LEDs).

Behaviour:
- Reset (rst_n low, async): sync flops, stable levels, counters, pend and sw_pulse all clear to 0. sw_level, sw_pulse and pend read 0 while in reset. All of these are registered outputs.
- Synchroniser: 2-FF per channel (sync1, sync2). It runs regardless of ena.
- Debounce, per channel, on each edge with ena=1:
  - sync2==stable: cnt<=0.
  - sync2!=stable and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0.
  - Any single-cycle agreement restarts the count; glitches shorter than DEBOUNCE_CYCLES cycles never change stable.
- Rise event: the edge on which stable goes 0->1 also sets pend[ch].
  - Falling transitions generate no event.
  - A rise while pend[ch] is already 1 is absorbed; no double count.
- Arbiter, each edge with ena=1:
  - sw_pulse <= lowest-index set bit of pend (D > N > R > P priority).
  - That pend bit clears on the same edge.
  - If pend==0, sw_pulse<=0.
  - A rise on channel ch and a grant of ch on the same edge: the grant clears the old request and the new rise re-sets pend[ch]. Net result is that pend[ch] stays 1.
- Latency, uncontended, ena=1, level held:
  - raw sampled high at edge 0;
  - sync2 high after edge 1;
  - stable (sw_level) high after edge 1+DEBOUNCE_CYCLES;
  - sw_pulse high for exactly one cycle after edge 2+DEBOUNCE_CYCLES.
- Contention: k simultaneous rises are issued on k consecutive cycles in priority order.
- ena=0:
  - counters, stable and pend hold;
  - sw_pulse is forced to 0 on the next edge;
  - no grants occur.
  - When ena returns to 1, issuing resumes from the held pend.
- Reset mid-operation discards all pending presses; no event is emitted after reset release until a fresh debounced rise.

Decomposition:
- Package tt_maquina_pkg:
  - N_CH;
  - channel indices CH_D=0, CH_N=1, CH_R=2, CH_P=3;
  - default DEBOUNCE_CYCLES.
  - It is shared with tt_Maquina_Top and the wrapper for sw ordering.
- Sub-module tt_debounce_ch: one channel's 2-FF sync, counter, stable register and rise strobe. It is instantiated N_CH times via generate.
- The arbiter and pend register stay in the top of this block.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: sw_raw=0001 from edge 0, held -> sw_level[0]=1 after edge 5; sw_pulse=0001 for one cycle after edge 6, then 0000.
- Glitch rejection: sw_raw[1] high for 3 cycles then low -> sw_level and sw_pulse stay 0000 throughout.
- Simultaneous press: sw_raw 0000->0101 in one cycle -> sw_pulse=0001 after edge 6, 0100 after edge 7; pend goes 0101 -> 0100 -> 0000.
- Release and re-press: hold D, release for 6 cycles, press again -> exactly two 0001 pulses and none on release; sw_level[0] falls 5 edges after release is sampled.
- ena gating: ena=0 while pend=1000 for 10 cycles -> sw_pulse stays 0 and pend holds 1000; with ena=1, sw_pulse=1000 on the next edge.
- Async reset: assert rst_n low mid-cycle with pend=0110 -> sw_level, sw_pulse and pend read 0000 before the next clk edge; no pulse follows reset release while sw_raw=0000.

Source files
------------

// File: rtl/tt_coin_input_conditioner_pkg.sv
// Shared definitions for the vending-machine front end and core:
// channel count, switch bit ordering {P,R,N,D} and default debounce length.
package tt_maquina_pkg;

   localparam int unsigned N_CH                = 4;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

   // Bit position of each coin/command switch in sw_raw; D has top priority.
   typedef enum int unsigned {
      CH_D = 0,
      CH_N = 1,
      CH_R = 2,
      CH_P = 3
   } ch_idx_e;

endpackage

// File: rtl/tt_coin_input_conditioner_if.sv
// Switch bus between the board/wrapper (master) and the input conditioner (slave).
interface tt_coin_input_conditioner_if #(
   parameter int unsigned N_CH = tt_maquina_pkg::N_CH
);

   logic [N_CH-1:0] sw_raw;
   logic [N_CH-1:0] sw_level;
   logic [N_CH-1:0] sw_pulse;
   logic [N_CH-1:0] pend;

   modport master (
      output sw_raw,
      input  sw_level,
      input  sw_pulse,
      input  pend
   );

   modport slave (
      input  sw_raw,
      output sw_level,
      output sw_pulse,
      output pend
   );

endinterface

// File: rtl/tt_coin_input_conditioner_debounce.sv
// One switch channel: 2-FF synchroniser, debounce counter, stable level and
// a rise strobe asserted on the edge where the stable level goes 0->1.
module tt_debounce_ch #(
   parameter int unsigned DEBOUNCE_CYCLES = tt_maquina_pkg::DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   import tt_maquina_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             rise;

   // Any single cycle of agreement restarts the count, so glitches never win.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise     = 1'b0;
      if (ena) begin
         if (sync2_q == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise     = sync2_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise;

endmodule

// File: rtl/tt_coin_input_conditioner.sv
// Coin/command input front end: per-channel debounce, then a fixed-priority
// arbiter that issues at most one single-cycle press event per clock.
module tt_coin_input_conditioner #(
   parameter int unsigned N_CH            = tt_maquina_pkg::N_CH,
   parameter int unsigned DEBOUNCE_CYCLES = tt_maquina_pkg::DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ena,
   tt_coin_input_conditioner_if.slave  bus
);

   import tt_maquina_pkg::*;

   logic [N_CH-1:0] level;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] grant;
   logic [N_CH-1:0] pend_q;
   logic [N_CH-1:0] pend_d;
   logic [N_CH-1:0] pulse_q;
   logic [N_CH-1:0] pulse_d;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tt_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .ena     (ena),
         .raw_i   (bus.sw_raw[g]),
         .level_o (level[g]),
         .rise_o  (rise[g])
      );
   end

   // Lowest index wins; a same-edge rise on the granted channel re-arms its request.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      if (ena) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (pend_q[i] && !found) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      pulse_d = grant;
      pend_d  = (pend_q & ~grant) | rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         pulse_q <= '0;
      end else begin
         pend_q  <= pend_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.sw_level = level;
   assign bus.sw_pulse = pulse_q;
   assign bus.pend     = pend_q;

endmodule

// File: tb/tb_tt_coin_input_conditioner.sv
// Scoreboard bench for tt_coin_input_conditioner with DEBOUNCE_CYCLES=4:
// each driven cycle queues the outputs expected after the following edge.
module tb_tt_coin_input_conditioner;

   import tt_maquina_pkg::*;

   localparam int unsigned DB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic ena   = 1'b0;

   tt_coin_input_conditioner_if #(.N_CH(4)) bus ();

   tt_coin_input_conditioner #(
      .N_CH            (4),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] lvl;
      logic [3:0] pls;
      logic [3:0] pnd;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq({e.tag, ".level"}, {4'b0, bus.sw_level}, {4'b0, e.lvl});
         check_eq({e.tag, ".pulse"}, {4'b0, bus.sw_pulse}, {4'b0, e.pls});
         check_eq({e.tag, ".pend"},  {4'b0, bus.pend},     {4'b0, e.pnd});
      end
   end

   // Drive one cycle of stimulus and queue what must be seen after the next edge.
   task automatic step(input logic [3:0] raw, input logic en, input logic [3:0] l,
                       input logic [3:0] p, input logic [3:0] q, input string tag);
      exp_t e;
      @(negedge clk);
      bus.sw_raw = raw;
      ena        = en;
      e.tag = tag; e.lvl = l; e.pls = p; e.pnd = q;
      sb.push_back(e);
   endtask

   // Uncontended press held from edge 0: level after 5, pend at 5, pulse at 6.
   task automatic press(input logic [3:0] m, input string tag);
      for (int k = 0; k <= 10; k++)
         step(m, 1'b1, (k >= 5) ? m : 4'b0, (k == 6) ? m : 4'b0, (k == 5) ? m : 4'b0, tag);
   endtask

   task automatic release_all(input logic [3:0] held, input string tag);
      for (int k = 0; k <= 7; k++)
         step(4'b0, 1'b1, (k < 5) ? held : 4'b0, 4'b0, 4'b0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] md, mn, mr, mp;
      md = 4'(1 << CH_D);
      mn = 4'(1 << CH_N);
      mr = 4'(1 << CH_R);
      mp = 4'(1 << CH_P);
      bus.sw_raw = '0;

      #2 rst_n = 1'b0;
      #1;
      check_eq("rst.level", {4'b0, bus.sw_level}, 8'h00);
      check_eq("rst.pulse", {4'b0, bus.sw_pulse}, 8'h00);
      check_eq("rst.pend",  {4'b0, bus.pend},     8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      press(md, "clean");

      // Release for 6 cycles then press again: second pulse, none on release.
      for (int k = 0; k <= 5; k++)
         step(4'b0, 1'b1, (k < 5) ? md : 4'b0, 4'b0, 4'b0, "release");
      press(md, "repress");
      release_all(md, "rel_d");

      for (int k = 0; k <= 11; k++)
         step((k < 3) ? mn : 4'b0, 1'b1, 4'b0, 4'b0, 4'b0, "glitch");

      for (int k = 0; k <= 10; k++)
         step(md | mr, 1'b1,
              (k >= 5) ? (md | mr) : 4'b0,
              (k == 6) ? md : ((k == 7) ? mr : 4'b0),
              (k == 5) ? (md | mr) : ((k == 6) ? mr : 4'b0),
              "simul");
      release_all(md | mr, "rel_dr");

      for (int k = 0; k <= 18; k++)
         step(mp, (k <= 5 || k >= 16),
              (k >= 5) ? mp : 4'b0,
              (k == 16) ? mp : 4'b0,
              (k >= 5 && k <= 15) ? mp : 4'b0,
              "ena_gate");
      release_all(mp, "rel_p");

      for (int k = 0; k <= 5; k++)
         step(mn | mr, 1'b1, (k >= 5) ? (mn | mr) : 4'b0, 4'b0,
              (k == 5) ? (mn | mr) : 4'b0, "pre_rst");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("arst.level", {4'b0, bus.sw_level}, 8'h00);
      check_eq("arst.pulse", {4'b0, bus.sw_pulse}, 8'h00);
      check_eq("arst.pend",  {4'b0, bus.pend},     8'h00);
      bus.sw_raw = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 9; k++)
         step(4'b0, 1'b1, 4'b0, 4'b0, 4'b0, "post_rst");

      repeat (2) @(negedge clk);
      check_eq("sb_drained", 8'(sb.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
